// File: rtl/escalonador_display.sv
// Time-multiplexed scan driver for a four-digit seven-segment display.
// Define ESCALONADOR_APAGAMENTO_EN to insert one blank tick slot between digits (anti-ghosting).
module escalonador_display #(
  parameter int ANODO_ATIVO_BAIXO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_multiplex,
  input  logic [15:0] valor,
  input  logic [3:0]  habilita,
  output logic [3:0]  anodo,
  output logic [6:0]  segmentos,
  output logic [1:0]  digito_ativo
);

  typedef enum logic [1:0] {OCIOSO, DIGITO, APAGADO} estado_t;

  localparam logic [3:0] ANODO_INATIVO = (ANODO_ATIVO_BAIXO != 0) ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_APAGADO   = 7'h7F;

  estado_t     estado_q;
  logic        tick_q;
  logic [3:0]  anodo_q;
  logic [6:0]  segmentos_q;
  logic [1:0]  digito_q;
  logic [3:0]  valor_cap_q;

  logic        avanco;
  logic [1:0]  idx_prox_d;
  logic [3:0]  nib_d;

  // First enabled index in the order base+1, base+2, base+3, base (mod 4).
  function automatic logic [1:0] proximo(input logic [3:0] hab, input logic [1:0] base);
    logic [1:0] cand;
    proximo = base;
    for (int k = 3; k >= 0; k--) begin
      cand = base + 2'(k + 1);
      if (hab[cand]) proximo = cand;
    end
  endfunction

  function automatic logic [6:0] decodifica(input logic [3:0] v);
    case (v)
      4'h0: decodifica = 7'h40;
      4'h1: decodifica = 7'h79;
      4'h2: decodifica = 7'h24;
      4'h3: decodifica = 7'h30;
      4'h4: decodifica = 7'h19;
      4'h5: decodifica = 7'h12;
      4'h6: decodifica = 7'h02;
      4'h7: decodifica = 7'h78;
      4'h8: decodifica = 7'h00;
      4'h9: decodifica = 7'h10;
      4'hA: decodifica = 7'h08;
      4'hB: decodifica = 7'h03;
      4'hC: decodifica = 7'h46;
      4'hD: decodifica = 7'h21;
      4'hE: decodifica = 7'h06;
      default: decodifica = 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] anodo_ativo(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    anodo_ativo = (ANODO_ATIVO_BAIXO != 0) ? ~oh : oh;
  endfunction

  assign avanco = tick_multiplex & ~tick_q;

  // From idle the search starts at index 0, which is "after" index 3.
  always_comb begin
    idx_prox_d = proximo(habilita, (estado_q == OCIOSO) ? 2'd3 : digito_q);
    nib_d      = valor[{idx_prox_d, 2'b00} +: 4];
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; the async reset branch blanks the display without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      tick_q      <= 1'b0;
      anodo_q     <= ANODO_INATIVO;
      segmentos_q <= SEG_APAGADO;
      digito_q    <= 2'd0;
      valor_cap_q <= 4'd0;
    end else begin
      tick_q <= tick_multiplex;
      if (avanco) begin
        if (habilita == 4'd0) begin
          estado_q    <= OCIOSO;
          anodo_q     <= ANODO_INATIVO;
          segmentos_q <= SEG_APAGADO;
          digito_q    <= 2'd0;
        end else if (estado_q == DIGITO) begin
`ifdef ESCALONADOR_APAGAMENTO_EN
          estado_q    <= APAGADO;
          anodo_q     <= ANODO_INATIVO;
          segmentos_q <= SEG_APAGADO;
`else
          estado_q    <= DIGITO;
          digito_q    <= idx_prox_d;
          anodo_q     <= anodo_ativo(idx_prox_d);
          valor_cap_q <= nib_d;
          segmentos_q <= decodifica(nib_d);
`endif
        end else begin
          estado_q    <= DIGITO;
          digito_q    <= idx_prox_d;
          anodo_q     <= anodo_ativo(idx_prox_d);
          valor_cap_q <= nib_d;
          segmentos_q <= decodifica(nib_d);
        end
      end else if (estado_q == DIGITO) begin
        // Glyph is held from the nibble captured at slot entry, never from live valor.
        segmentos_q <= decodifica(valor_cap_q);
      end
    end
  end

  assign anodo        = anodo_q;
  assign segmentos    = segmentos_q;
  assign digito_ativo = digito_q;

endmodule

// File: tb/tb_escalonador_display.sv
// Self-checking bench for escalonador_display: scan model compared every cycle plus directed literals.
module tb_escalonador_display;

  localparam int ANODO_ATIVO_BAIXO = 1;
`ifdef ESCALONADOR_APAGAMENTO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam int STEP = BLANK ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [15:0] valor;
  logic [3:0]  habilita;
  logic [3:0]  anodo;
  logic [6:0]  segmentos;
  logic [1:0]  digito_ativo;

  int n_checks = 0;
  int n_errors = 0;

  escalonador_display #(.ANODO_ATIVO_BAIXO(ANODO_ATIVO_BAIXO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_multiplex (tick),
    .valor          (valor),
    .habilita       (habilita),
    .anodo          (anodo),
    .segmentos      (segmentos),
    .digito_ativo   (digito_ativo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         m_mode;   // 0 = display idle, 1 = a digit lit, 2 = blank gap
  int         m_idx;
  logic [3:0] m_nib;
  bit         m_prev;

  function automatic int prox(input logic [3:0] h, input int base);
    for (int k = 1; k <= 4; k++) if (h[(base + k) % 4]) return (base + k) % 4;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_idx = 0; m_nib = 4'd0; m_prev = 1'b0;
    end else begin
      if (tick && !m_prev) begin
        if (habilita == 4'd0) begin
          m_mode = 0; m_idx = 0;
        end else if (m_mode == 1 && BLANK) begin
          m_mode = 2;
        end else begin
          m_idx  = (m_mode == 0) ? prox(habilita, 3) : prox(habilita, m_idx);
          m_nib  = valor[4*m_idx +: 4];
          m_mode = 1;
        end
      end
      m_prev = tick;
    end
  end

  function automatic logic [3:0] exp_anodo();
    logic [3:0] oh;
    oh = (m_mode == 1) ? (4'b0001 << m_idx) : 4'b0000;
    return (ANODO_ATIVO_BAIXO != 0) ? ~oh : oh;
  endfunction

  always @(negedge clk) begin
    check("cyc_anodo", {28'd0, anodo}, {28'd0, exp_anodo()});
    check("cyc_seg", {25'd0, segmentos}, {25'd0, (m_mode == 1) ? seg_tab[m_nib] : 7'h7F});
    check("cyc_digito", {30'd0, digito_ativo}, m_idx);
    check("cyc_onehot", ($countones(~anodo) <= 1) ? 32'd1 : 32'd0, 32'd1);
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input int hold);
    @(negedge clk) tick = 1'b1;
    repeat (hold) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [6:0] s29_seg [5];
  int         s29_dig [5];
  logic [3:0] s30_an  [4];

  initial begin
`ifdef ESCALONADOR_APAGAMENTO_EN
    s29_seg = '{7'h19, 7'h7F, 7'h30, 7'h7F, 7'h24};
    s29_dig = '{0, 0, 1, 1, 2};
    s30_an  = '{4'b1110, 4'hF, 4'b1011, 4'hF};
`else
    s29_seg = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
    s29_dig = '{0, 1, 2, 3, 0};
    s30_an  = '{4'b1110, 4'b1011, 4'b1110, 4'b1011};
`endif
    rst_n = 1'b0; tick = 1'b0; valor = 16'h0000; habilita = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_anodo", {28'd0, anodo}, 32'hF);
    check("rst_seg", {25'd0, segmentos}, 32'h7F);
    check("rst_digito", {30'd0, digito_ativo}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle with nothing enabled: ticks keep the display dark.
    pulse(1);
    check("idle_anodo", {28'd0, anodo}, 32'hF);

    // Scan all four digits of 1234.
    habilita = 4'hF; valor = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      pulse(1);
      check($sformatf("scan_seg%0d", i), {25'd0, segmentos}, {25'd0, s29_seg[i]});
      check($sformatf("scan_dig%0d", i), {30'd0, digito_ativo}, s29_dig[i]);
    end

    // Sparse enable mask 0101.
    do_reset();
    habilita = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      pulse(1);
      check($sformatf("mask_anodo%0d", i), {28'd0, anodo}, {28'd0, s30_an[i]});
    end

    // valor change inside a slot must not reach the segments until re-entry.
    do_reset();
    habilita = 4'hF; valor = 16'h1234;
    repeat (1 + STEP) pulse(1);
    check("hold_dig", {30'd0, digito_ativo}, 32'd1);
    valor = 16'h1284;
    repeat (3) @(negedge clk);
    check("hold_seg", {25'd0, segmentos}, 32'h30);
    repeat (4 * STEP) pulse(1);
    check("reentry_dig", {30'd0, digito_ativo}, 32'd1);
    check("reentry_seg", {25'd0, segmentos}, 32'h00);

    // Mask drops to zero while driving digit 2, then a long-held tick.
    do_reset();
    habilita = 4'hF; valor = 16'hA5C3;
    repeat (1 + 2 * STEP) pulse(1);
    check("drop_pre_dig", {30'd0, digito_ativo}, 32'd2);
    habilita = 4'h0;
    pulse(1);
    check("drop_anodo", {28'd0, anodo}, 32'hF);
    check("drop_dig", {30'd0, digito_ativo}, 32'd0);
    check("drop_seg", {25'd0, segmentos}, 32'h7F);
    habilita = 4'hF;
    pulse(1000);
    check("held_dig", {30'd0, digito_ativo}, 32'd0);
    check("held_anodo", {28'd0, anodo}, 32'hE);

    // Single enabled digit plus every glyph of the decoder.
    do_reset();
    habilita = 4'b1000;
    for (int n = 0; n < 16; n++) begin
      valor = {4{4'(n)}};
      repeat (STEP) pulse(1);
      check($sformatf("single_dig%0d", n), {30'd0, digito_ativo}, 32'd3);
    end
    habilita = 4'b0001; valor = 16'h000B;
    repeat (STEP) pulse(1);
    check("glyph_b", {25'd0, segmentos}, 32'h03);

    // Asynchronous reset in the middle of a slot.
    habilita = 4'b0010; valor = 16'h00E0;
    repeat (2 * STEP) pulse(1);
    check("pre_async_anodo", {28'd0, anodo}, 32'hD);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_anodo", {28'd0, anodo}, 32'hF);
    check("async_seg", {25'd0, segmentos}, 32'h7F);
    check("async_dig", {30'd0, digito_ativo}, 32'd0);

    // Tick already high when reset releases counts as a rising edge.
    habilita = 4'b0110; valor = 16'h0D00;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rel_dig", {30'd0, digito_ativo}, 32'd1);
    check("rel_anodo", {28'd0, anodo}, 32'hD);
    tick = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
